// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches words over a req/valid
// handshake, holds the instruction for the core and forms the next PC.
module instr_fetch_unit #(
    parameter int              AW       = 16,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter int              MAX_WAIT = 255
) (
    input  logic          CLK,
    input  logic          RST_N,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          imem_valid,
    output logic [31:0]   instr,
    output logic [4:0]    opcode,
    output logic          instr_valid,
    input  logic          advance,
    input  logic          pcSrc,
    input  logic          C_offset,
    output logic [AW-1:0] pc,
    output logic          fetch_err
);

    // Counter only has to reach MAX_WAIT-1, the last allowed FETCH cycle.
    localparam int            CW       = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        ERR
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] wait_cnt;
    logic          timeout;

    function automatic logic [AW-1:0] next_pc_calc(
        input logic [AW-1:0] cur_pc,
        input logic [31:0]   cur_instr,
        input logic          src,
        input logic          rel
    );
        logic signed [AW-1:0] offset;
        logic [AW-1:0]        seq_pc;
        offset = AW'($signed(cur_instr[15:0]));
        seq_pc = cur_pc + AW'(1);
        if (!src)
            return seq_pc;
        else if (!rel)
            return cur_instr[AW-1:0];
        else
            return seq_pc + $unsigned(offset);
    endfunction

    assign timeout = (wait_cnt == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (!RST_N)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH: begin
                // A response on the last allowed cycle beats the timeout.
                if (imem_valid)
                    state_d = ISSUE;
                else if (timeout)
                    state_d = ERR;
            end
            ISSUE: begin
                if (advance)
                    state_d = FETCH;
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc       <= RESET_PC;
            instr    <= '0;
            wait_cnt <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_valid) begin
                        instr    <= imem_rdata;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    if (advance)
                        pc <= next_pc_calc(pc, instr, pcSrc, C_offset);
                end
                default: ;
            endcase
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == ISSUE);
    assign fetch_err   = (state_q == ERR);
    assign imem_addr   = pc;
    assign opcode      = instr[31:27];

endmodule
